// File: rtl/cpu_core.sv
// cpu_core: 5-stage in-order RV32I pipeline (IF, ID, EX, MEM, WB).
// Define FORWARD_EN to add EX-stage operand forwarding and the load-use interlock.
module cpu_core_reg_file (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] REGISTERS [0:31];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) REGISTERS[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      REGISTERS[waddr] <= wdata;
    end
  // write-through so ID sees the value WB is committing this cycle
  assign rdata1 = (raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : REGISTERS[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : REGISTERS[raddr2];
endmodule

module cpu_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION,
  output logic [3:0]  DATA_MEM_READ,
  output logic [2:0]  DATA_MEM_WRITE,
  output logic [31:0] DATA_MEM_ADDR,
  output logic [31:0] DATA_MEM_WRITE_DATA,
  input  logic [31:0] DATA_MEM_READ_DATA,
  input  logic        DATA_MEM_BUSYWAIT,
  input  logic        INSTR_MEM_BUSYWAIT
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        stall, load_use, taken, cond, wb;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
  logic [31:0] if_id_pc, if_id_ir, id_ex_pc, id_ex_ir, id_ex_a, id_ex_b, rd1, rd2;
  logic [31:0] ex_mem_res, ex_mem_b, mem_wb_val;
  logic [4:0]  ex_mem_rd, mem_wb_rd, rd, sh;
  logic        ex_mem_wb, ex_mem_ld, ex_mem_st, mem_wb_wb;
  logic [2:0]  ex_mem_f3, f3;
  logic [6:0]  op;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] a, b, alu_b, alu, sra, res, target;

  assign stall = DATA_MEM_BUSYWAIT | INSTR_MEM_BUSYWAIT;

  cpu_core_reg_file ID_REG_FILE (
    .clk(CLK), .rst_n(RESET), .we(mem_wb_wb & ~stall), .waddr(mem_wb_rd), .wdata(mem_wb_val),
    .raddr1(if_id_ir[19:15]), .raddr2(if_id_ir[24:20]), .rdata1(rd1), .rdata2(rd2)
  );

  assign op = id_ex_ir[6:0];
  assign f3 = id_ex_ir[14:12];
  assign rd = id_ex_ir[11:7];
  assign is_lui   = op == 7'b0110111;
  assign is_auipc = op == 7'b0010111;
  assign is_jal   = op == 7'b1101111;
  assign is_jalr  = op == 7'b1100111;
  assign is_br    = op == 7'b1100011;
  assign is_ld    = op == 7'b0000011;
  assign is_st    = op == 7'b0100011;
  assign is_opi   = op == 7'b0010011;
  assign is_op    = op == 7'b0110011;

  assign imm_i = {{20{id_ex_ir[31]}}, id_ex_ir[31:20]};
  assign imm_s = {{20{id_ex_ir[31]}}, id_ex_ir[31:25], id_ex_ir[11:7]};
  assign imm_b = {{19{id_ex_ir[31]}}, id_ex_ir[31], id_ex_ir[7], id_ex_ir[30:25], id_ex_ir[11:8], 1'b0};
  assign imm_u = {id_ex_ir[31:12], 12'b0};
  assign imm_j = {{11{id_ex_ir[31]}}, id_ex_ir[31], id_ex_ir[19:12], id_ex_ir[20], id_ex_ir[30:21], 1'b0};

`ifdef FORWARD_EN
  // EX/MEM wins over MEM/WB; wb flags are already cleared for rd == x0
  assign a = (ex_mem_wb && ex_mem_rd == id_ex_ir[19:15]) ? ex_mem_res :
             (mem_wb_wb && mem_wb_rd == id_ex_ir[19:15]) ? mem_wb_val : id_ex_a;
  assign b = (ex_mem_wb && ex_mem_rd == id_ex_ir[24:20]) ? ex_mem_res :
             (mem_wb_wb && mem_wb_rd == id_ex_ir[24:20]) ? mem_wb_val : id_ex_b;
  assign load_use = is_ld && rd != 5'd0 && (rd == if_id_ir[19:15] || rd == if_id_ir[24:20]);
`else
  assign a = id_ex_a;
  assign b = id_ex_b;
  assign load_use = 1'b0;
`endif

  assign alu_b = is_op ? b : imm_i;
  assign sh = alu_b[4:0];
  assign sra = $signed(a) >>> sh;
  always_comb
    case (f3)
      3'd0: alu = (is_op && id_ex_ir[30]) ? a - alu_b : a + alu_b;
      3'd1: alu = a << sh;
      3'd2: alu = {31'b0, $signed(a) < $signed(alu_b)};
      3'd3: alu = {31'b0, a < alu_b};
      3'd4: alu = a ^ alu_b;
      3'd5: alu = id_ex_ir[30] ? sra : a >> sh;
      3'd6: alu = a | alu_b;
      default: alu = a & alu_b;
    endcase

  assign res = is_lui ? imm_u : is_auipc ? id_ex_pc + imm_u : (is_jal | is_jalr) ? id_ex_pc + 32'd4 :
               is_ld ? a + imm_i : is_st ? a + imm_s : alu;
  assign wb = (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op) && rd != 5'd0;
  assign cond = f3 == 3'd0 ? a == b : f3 == 3'd1 ? a != b : f3 == 3'd4 ? $signed(a) < $signed(b) :
                f3 == 3'd5 ? $signed(a) >= $signed(b) : f3 == 3'd6 ? a < b : f3 == 3'd7 ? a >= b : 1'b0;
  assign taken = is_jal | is_jalr | (is_br & cond);
  assign target = is_jalr ? (a + imm_i) & ~32'd1 : id_ex_pc + (is_jal ? imm_j : imm_b);

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      PC         <= RESET_PC;
      if_id_pc   <= '0;
      if_id_ir   <= NOP;
      id_ex_pc   <= '0;
      id_ex_ir   <= NOP;
      id_ex_a    <= '0;
      id_ex_b    <= '0;
      ex_mem_res <= '0;
      ex_mem_b   <= '0;
      ex_mem_rd  <= '0;
      ex_mem_wb  <= 1'b0;
      ex_mem_ld  <= 1'b0;
      ex_mem_st  <= 1'b0;
      ex_mem_f3  <= '0;
      mem_wb_val <= '0;
      mem_wb_rd  <= '0;
      mem_wb_wb  <= 1'b0;
    end else if (!stall) begin
      PC <= taken ? target : load_use ? PC : PC + 32'd4;
      if (taken) begin
        if_id_ir <= NOP;
      end else if (!load_use) begin
        if_id_pc <= PC;
        if_id_ir <= INSTRUCTION;
      end
      id_ex_pc   <= if_id_pc;
      id_ex_ir   <= (taken | load_use) ? NOP : if_id_ir;
      id_ex_a    <= rd1;
      id_ex_b    <= rd2;
      ex_mem_res <= res;
      ex_mem_b   <= b;
      ex_mem_rd  <= rd;
      ex_mem_wb  <= wb;
      ex_mem_ld  <= is_ld;
      ex_mem_st  <= is_st;
      ex_mem_f3  <= f3;
      mem_wb_val <= ex_mem_ld ? DATA_MEM_READ_DATA : ex_mem_res;
      mem_wb_rd  <= ex_mem_rd;
      mem_wb_wb  <= ex_mem_wb;
    end

  assign DATA_MEM_READ       = ex_mem_ld ? {1'b1, ex_mem_f3} : 4'd0;
  assign DATA_MEM_WRITE      = ex_mem_st ? {1'b1, ex_mem_f3[1:0]} : 3'd0;
  assign DATA_MEM_ADDR       = (ex_mem_ld | ex_mem_st) ? ex_mem_res : '0;
  assign DATA_MEM_WRITE_DATA = ex_mem_st ? ex_mem_b : '0;
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed checks of reset, writeback timing, store/load, branch flush, stalls and async reset.
module tb_cpu_core;
  logic        CLK = 1'b0, RESET = 1'b0, DATA_MEM_BUSYWAIT = 1'b0, INSTR_MEM_BUSYWAIT = 1'b0, rom_mode = 1'b0;
  logic [31:0] PC, INSTRUCTION, DATA_MEM_ADDR, DATA_MEM_WRITE_DATA;
  logic [31:0] instr = 32'h0000_0013, DATA_MEM_READ_DATA = 32'h0;
  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] imem [0:63];
  int compared = 0, mismatched = 0;

  always #5 CLK = ~CLK;
  assign INSTRUCTION = rom_mode ? imem[PC[7:2]] : instr;

  cpu_core dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
    .DATA_MEM_READ(DATA_MEM_READ), .DATA_MEM_WRITE(DATA_MEM_WRITE), .DATA_MEM_ADDR(DATA_MEM_ADDR),
    .DATA_MEM_WRITE_DATA(DATA_MEM_WRITE_DATA), .DATA_MEM_READ_DATA(DATA_MEM_READ_DATA),
    .DATA_MEM_BUSYWAIT(DATA_MEM_BUSYWAIT), .INSTR_MEM_BUSYWAIT(INSTR_MEM_BUSYWAIT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  function automatic logic [31:0] xr(input int i);
    return dut.ID_REG_FILE.REGISTERS[i];
  endfunction

  function automatic logic [31:0] nonzero_regs();
    int n = 0;
    for (int i = 0; i < 32; i++) if (dut.ID_REG_FILE.REGISTERS[i] !== 32'h0) n++;
    return 32'(n);
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
    imem[8]  = 32'h0000_0863; // 0x20 beq x0,x0,+16
    imem[9]  = 32'h0050_0313; // 0x24 addi x6,x0,5   (flushed)
    imem[10] = 32'h0000_2223; // 0x28 sw x0,4(x0)    (flushed)
    imem[12] = 32'h0090_0393; // 0x30 addi x7,x0,9
    imem[15] = 32'h0030_0493; // 0x3C addi x9,x0,3
    imem[16] = 32'h0070_2623; // 0x40 sw x7,12(x0)
    imem[17] = 32'h0070_2823; // 0x44 sw x7,16(x0)

    tick(2);
    check("rst_pc", PC, 32'h0);
    check("rst_read", 32'(DATA_MEM_READ), 32'h0);
    check("rst_write", 32'(DATA_MEM_WRITE), 32'h0);
    check("rst_addr", DATA_MEM_ADDR, 32'h0);
    check("rst_wdata", DATA_MEM_WRITE_DATA, 32'h0);
    check("rst_regs", nonzero_regs(), 32'h0);
    RESET = 1'b1;

    instr = 32'h0000_10B7; // lui x1,0x1
    tick(5);
    check("lui_x1", xr(1), 32'h0000_1000);
    check("lui_nz", nonzero_regs(), 32'd1);
    check("lui_rd3", 32'(DATA_MEM_READ[3]), 32'h0);
    check("lui_wr2", 32'(DATA_MEM_WRITE[2]), 32'h0);
    check("lui_pc", PC, 32'h14);

    instr = 32'h0070_0193; // addi x3,x0,7
    tick(5);
    check("addi_x3", xr(3), 32'd7);
    check("addi_x1", xr(1), 32'h0000_1000);

    instr = 32'h0030_A423; // sw x3,8(x1)
    tick();
    instr = 32'h0000_0013;
    tick(2);
    check("sw_write", 32'(DATA_MEM_WRITE), 32'b110);
    check("sw_addr", DATA_MEM_ADDR, 32'h1008);
    check("sw_wdata", DATA_MEM_WRITE_DATA, 32'd7);
    check("sw_read", 32'(DATA_MEM_READ), 32'h0);
    tick();
    check("sw_done", 32'(DATA_MEM_WRITE), 32'h0);
    check("sw_nz", nonzero_regs(), 32'd2);

    instr = 32'h0000_A283; // lw x5,0(x1)
    tick();
    instr = 32'h0000_0013;
    tick(2);
    check("lw_read", 32'(DATA_MEM_READ), 32'b1010);
    check("lw_addr", DATA_MEM_ADDR, 32'h1000);
    check("lw_write", 32'(DATA_MEM_WRITE), 32'h0);
    DATA_MEM_READ_DATA = 32'hDEAD_BEEF;
    tick();
    check("lw_x5_early", xr(5), 32'h0);
    check("lw_done", 32'(DATA_MEM_READ), 32'h0);
    DATA_MEM_READ_DATA = 32'h0;
    tick();
    check("lw_x5", xr(5), 32'hDEAD_BEEF);

    RESET = 1'b0;
    #2;
    rom_mode = 1'b1;
    RESET = 1'b1;
    n = 0;
    while (PC !== 32'h20 && n < 40) begin
      tick();
      n++;
    end
    check("reach_20", PC, 32'h20);
    tick();
    check("br_pc24", PC, 32'h24);
    tick();
    check("br_pc28", PC, 32'h28);
    tick();
    check("br_target", PC, 32'h30);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("br_nowrite", 32'(DATA_MEM_WRITE), 32'h0);
    end
    check("br_x6", xr(6), 32'h0);
    check("br_x7", xr(7), 32'd9);
    tick();
    check("st1_write", 32'(DATA_MEM_WRITE), 32'b110);
    check("st1_addr", DATA_MEM_ADDR, 32'd12);
    check("st1_wdata", DATA_MEM_WRITE_DATA, 32'd9);
    check("st1_pc", PC, 32'h4C);

    DATA_MEM_BUSYWAIT = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", PC, 32'h4C);
      check("stall_addr", DATA_MEM_ADDR, 32'd12);
      check("stall_x9", xr(9), 32'h0);
    end
    DATA_MEM_BUSYWAIT = 1'b0;
    tick();
    check("resume_x9", xr(9), 32'd3);
    check("resume_pc", PC, 32'h50);
    check("resume_addr", DATA_MEM_ADDR, 32'd16);
    INSTR_MEM_BUSYWAIT = 1'b1;
    tick();
    check("istall_pc", PC, 32'h50);
    check("istall_addr", DATA_MEM_ADDR, 32'd16);
    INSTR_MEM_BUSYWAIT = 1'b0;

    #2;
    RESET = 1'b0;
    #1;
    check("arst_pc", PC, 32'h0);
    check("arst_regs", nonzero_regs(), 32'h0);
    check("arst_read", 32'(DATA_MEM_READ), 32'h0);
    check("arst_write", 32'(DATA_MEM_WRITE), 32'h0);
    check("arst_addr", DATA_MEM_ADDR, 32'h0);
    check("arst_wdata", DATA_MEM_WRITE_DATA, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
